// File: rtl/param_apply_ctrl.sv
// param_apply_ctrl
//
// Sits between param_selector and the autotune audio datapath. The user can
// change parameters at any moment from button presses. This block commits a
// change to the datapath only at a frame boundary, while the pipeline is held.
// Rapid successive edits are coalesced into one update. If the datapath never
// acknowledges the hold, the block still commits and raises a sticky error.
//
// Ports:
//   clk_65mhz             in   system clock
//   rst_n                 in   asynchronous active-low reset
//   sampling_rate         in   [15:0] requested rate from param_selector
//   scale_factor          in   [2:0]  requested musical scale factor
//   mode                  in   [1:0]  requested display/processing mode
//   live                  in          requested live-input enable
//   frame_done            in          one-cycle pulse at datapath frame boundary
//   dp_idle               in          datapath idle (no frame in flight)
//   hold_ack              in          datapath has stalled in response to hold_req
//   clear_err             in          clears timeout_err
//   hold_req              out         request datapath stall
//   active_sampling_rate  out  [15:0] committed rate
//   active_scale_factor   out  [2:0]  committed scale
//   active_mode           out  [1:0]  committed mode
//   active_live           out         committed live
//   cfg_update            out         one-cycle pulse when active_* change
//   busy                  out         high whenever a transaction is in progress
//   timeout_err           out         sticky, set on hold_ack timeout

module param_apply_ctrl #(
  parameter logic [15:0] DEF_RATE       = 16'd8000,
  parameter logic [2:0]  DEF_SCALE      = 3'd0,
  parameter logic [1:0]  DEF_MODE       = 2'd0,
  parameter logic        DEF_LIVE       = 1'b0,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk_65mhz,
  input  logic        rst_n,
  input  logic [15:0] sampling_rate,
  input  logic [2:0]  scale_factor,
  input  logic [1:0]  mode,
  input  logic        live,
  input  logic        frame_done,
  input  logic        dp_idle,
  input  logic        hold_ack,
  input  logic        clear_err,
  output logic        hold_req,
  output logic [15:0] active_sampling_rate,
  output logic [2:0]  active_scale_factor,
  output logic [1:0]  active_mode,
  output logic        active_live,
  output logic        cfg_update,
  output logic        busy,
  output logic        timeout_err
);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_FRAME = 3'd1;
  localparam logic [2:0] ST_STALL      = 3'd2;
  localparam logic [2:0] ST_APPLY      = 3'd3;
  localparam logic [2:0] ST_SETTLE     = 3'd4;

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [TMO_W-1:0] tmo_cnt;
  logic [SET_W-1:0] settle_cnt;
  logic             diff;
  logic             timeout_fire;

  // Next-state logic. Requested parameters are compared against the committed
  // ones every cycle. A revert while waiting for a frame boundary abandons the
  // transaction; the revert test takes priority over a boundary in the same
  // cycle because there would be nothing left to commit.
  always_comb begin
    diff = {sampling_rate, scale_factor, mode, live} !=
           {active_sampling_rate, active_scale_factor, active_mode, active_live};
    next_state   = state;
    timeout_fire = 1'b0;
    case (state)
      ST_IDLE: begin
        if (diff) next_state = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: begin
        if (!diff)                      next_state = ST_IDLE;
        else if (frame_done || dp_idle) next_state = ST_STALL;
      end
      ST_STALL: begin
        if (hold_ack) begin
          next_state = ST_APPLY;
        end else if (tmo_cnt == TMO_LAST) begin
          next_state   = ST_APPLY;
          timeout_fire = 1'b1;
        end
      end
      ST_APPLY: begin
        next_state = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_cnt == SET_LAST) next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // State register and the two counters. Each counter runs only while its
  // state is held and returns to zero otherwise, so every entry starts from 0.
  always_ff @(posedge clk_65mhz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tmo_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == ST_STALL && next_state == ST_STALL) tmo_cnt <= tmo_cnt + TMO_W'(1);
      else                                             tmo_cnt <= '0;
      if (state == ST_SETTLE && next_state == ST_SETTLE) settle_cnt <= settle_cnt + SET_W'(1);
      else                                               settle_cnt <= '0;
    end
  end

  // Registered outputs. hold_req and busy are decoded from the upcoming state
  // so they line up exactly with the state register. The committed parameters
  // take the live input values in APPLY, which folds in any edits made while
  // waiting; cfg_update marks the cycle those new values first appear.
  always_ff @(posedge clk_65mhz or negedge rst_n) begin
    if (!rst_n) begin
      hold_req             <= 1'b0;
      busy                 <= 1'b0;
      cfg_update           <= 1'b0;
      active_sampling_rate <= DEF_RATE;
      active_scale_factor  <= DEF_SCALE;
      active_mode          <= DEF_MODE;
      active_live          <= DEF_LIVE;
    end else begin
      hold_req   <= (next_state == ST_STALL) || (next_state == ST_APPLY) ||
                    (next_state == ST_SETTLE);
      busy       <= (next_state != ST_IDLE);
      cfg_update <= (state == ST_APPLY);
      if (state == ST_APPLY) begin
        active_sampling_rate <= sampling_rate;
        active_scale_factor  <= scale_factor;
        active_mode          <= mode;
        active_live          <= live;
      end
    end
  end

  // Sticky timeout flag. A timeout in the same cycle as clear_err wins so an
  // error is never lost.
  always_ff @(posedge clk_65mhz or negedge rst_n) begin
    if (!rst_n)            timeout_err <= 1'b0;
    else if (timeout_fire) timeout_err <= 1'b1;
    else if (clear_err)    timeout_err <= 1'b0;
  end

endmodule

// File: tb/tb_param_apply_ctrl.sv
// tb_param_apply_ctrl
//
// Self-checking bench for param_apply_ctrl. A timeline model follows the
// commit rules transaction by transaction and predicts every output each
// cycle; directed scenarios cover reset, coalescing, revert, timeout and
// edits during settle, followed by a randomized phase.

module tb_param_apply_ctrl;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 4096;
  localparam logic [21:0] DEF_BUNDLE = {16'd8000, 3'd0, 2'd0, 1'b0};

  logic        clk_65mhz = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sampling_rate = 16'd8000;
  logic [2:0]  scale_factor = 3'd0;
  logic [1:0]  mode = 2'd0;
  logic        live = 1'b0;
  logic        frame_done = 1'b0;
  logic        dp_idle = 1'b0;
  logic        hold_ack = 1'b0;
  logic        clear_err = 1'b0;
  logic        hold_req;
  logic [15:0] active_sampling_rate;
  logic [2:0]  active_scale_factor;
  logic [1:0]  active_mode;
  logic        active_live;
  logic        cfg_update;
  logic        busy;
  logic        timeout_err;

  int check_count = 0;
  int fail_count = 0;
  int cfg_pulses = 0;
  int hold_cycles = 0;

  logic [21:0] m_active = DEF_BUNDLE;
  logic        m_hold = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_cfg = 1'b0;
  logic        m_err = 1'b0;

  param_apply_ctrl #(
    .DEF_RATE(16'd8000), .DEF_SCALE(3'd0), .DEF_MODE(2'd0), .DEF_LIVE(1'b0),
    .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_65mhz(clk_65mhz), .rst_n(rst_n),
    .sampling_rate(sampling_rate), .scale_factor(scale_factor), .mode(mode), .live(live),
    .frame_done(frame_done), .dp_idle(dp_idle), .hold_ack(hold_ack), .clear_err(clear_err),
    .hold_req(hold_req),
    .active_sampling_rate(active_sampling_rate), .active_scale_factor(active_scale_factor),
    .active_mode(active_mode), .active_live(active_live),
    .cfg_update(cfg_update), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk_65mhz = ~clk_65mhz;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] rate, input logic [2:0] scale,
                               input logic [1:0] md, input logic lv);
    sampling_rate = rate;
    scale_factor  = scale;
    mode          = md;
    live          = lv;
  endtask

  // Inputs always change 2 time units after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk_65mhz);
    #2;
  endtask

  task automatic waitHold(input int limit);
    int n = 0;
    while (hold_req !== 1'b1 && n < limit) begin
      step(1);
      n++;
    end
    checkOutput("wait_hold_req", 32'(hold_req), 32'd1);
  endtask

  task automatic waitIdle(input int limit);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin
      step(1);
      n++;
    end
    checkOutput("wait_idle", 32'(busy), 32'd0);
  endtask

  function automatic logic [21:0] requested();
    return {sampling_rate, scale_factor, mode, live};
  endfunction

  // One clock edge as the model sees it; reports an abort on reset assertion.
  task automatic tick(output bit abort);
    @(posedge clk_65mhz or negedge rst_n);
    abort = !rst_n;
    if (!abort) begin
      m_cfg = 1'b0;
      if (clear_err) m_err = 1'b0;
    end
  endtask

  // Transaction timeline: wait for a difference, wait for a boundary (or a
  // revert), wait for the ack (or give up after TIMEOUT stalled cycles),
  // commit the latest request, then hold for SETTLE cycles.
  task automatic runModel();
    bit ab;
    int waited;
    bit reverted;
    forever begin
      do begin
        tick(ab);
        if (ab) return;
      end while (requested() == m_active);
      m_busy = 1'b1;

      reverted = 1'b0;
      forever begin
        tick(ab);
        if (ab) return;
        if (requested() == m_active) begin
          reverted = 1'b1;
          break;
        end
        if (frame_done || dp_idle) break;
      end
      if (reverted) begin
        m_busy = 1'b0;
        continue;
      end

      m_hold = 1'b1;
      waited = 0;
      forever begin
        tick(ab);
        if (ab) return;
        if (hold_ack) break;
        if (waited == TIMEOUT - 1) begin
          m_err = 1'b1;
          break;
        end
        waited++;
      end

      tick(ab);
      if (ab) return;
      m_active = requested();
      m_cfg = 1'b1;

      repeat (SETTLE) begin
        tick(ab);
        if (ab) return;
      end
      m_hold = 1'b0;
      m_busy = 1'b0;
    end
  endtask

  initial begin
    forever begin
      m_active = DEF_BUNDLE;
      m_hold = 1'b0;
      m_busy = 1'b0;
      m_cfg = 1'b0;
      m_err = 1'b0;
      wait (rst_n === 1'b1);
      runModel();
    end
  end

  // Every cycle, compare all outputs with the model, away from the clock edge.
  always @(negedge clk_65mhz) begin
    checkOutput("hold_req", 32'(hold_req), 32'(m_hold));
    checkOutput("busy", 32'(busy), 32'(m_busy));
    checkOutput("cfg_update", 32'(cfg_update), 32'(m_cfg));
    checkOutput("timeout_err", 32'(timeout_err), 32'(m_err));
    checkOutput("active_bundle",
                32'({active_sampling_rate, active_scale_factor, active_mode, active_live}),
                32'(m_active));
    if (cfg_update === 1'b1) cfg_pulses++;
    if (hold_req === 1'b1) hold_cycles++;
  end

  initial begin
    int cfg0;
    int hold0;
    int hold_n;
    logic [15:0] rate_tab [4];
    rate_tab = '{16'd8000, 16'd16000, 16'd44100, 16'd48000};

    $display("[TB] starting param_apply_ctrl bench");
    step(3);
    checkOutput("reset_rate", 32'(active_sampling_rate), 32'd8000);
    checkOutput("reset_hold", 32'(hold_req), 32'd0);
    rst_n = 1'b1;
    step(2);

    // Reset asserted in the middle of SETTLE.
    applyStimulus(16'd12000, 3'd0, 2'd0, 1'b0);
    dp_idle = 1'b1;
    waitHold(10);
    dp_idle = 1'b0;
    hold_ack = 1'b1;
    step(1);
    hold_ack = 1'b0;
    step(6);
    checkOutput("s1_mid_settle_hold", 32'(hold_req), 32'd1);
    checkOutput("s1_mid_settle_rate", 32'(active_sampling_rate), 32'd12000);
    rst_n = 1'b0;
    applyStimulus(16'd8000, 3'd0, 2'd0, 1'b0);
    #1;
    checkOutput("s1_rst_rate", 32'(active_sampling_rate), 32'd8000);
    checkOutput("s1_rst_hold", 32'(hold_req), 32'd0);
    checkOutput("s1_rst_busy", 32'(busy), 32'd0);
    checkOutput("s1_rst_cfg", 32'(cfg_update), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(10);
    checkOutput("s1_post_busy", 32'(busy), 32'd0);
    checkOutput("s1_post_hold", 32'(hold_req), 32'd0);

    // Rate change, boundary five cycles later, ack three cycles after hold.
    cfg0 = cfg_pulses;
    applyStimulus(16'd16000, 3'd0, 2'd0, 1'b0);
    step(5);
    frame_done = 1'b1;
    step(1);
    frame_done = 1'b0;
    waitHold(10);
    step(3);
    hold_ack = 1'b1;
    @(negedge clk_65mhz);
    hold_n = (hold_req === 1'b1) ? 1 : 0;
    step(1);
    hold_ack = 1'b0;
    for (int c = 1; c < 100; c++) begin
      @(negedge clk_65mhz);
      if (c == 1) checkOutput("s2_rate_before_commit", 32'(active_sampling_rate), 32'd8000);
      if (c == 2) begin
        checkOutput("s2_rate_ack_plus2", 32'(active_sampling_rate), 32'd16000);
        checkOutput("s2_cfg_ack_plus2", 32'(cfg_update), 32'd1);
      end
      if (hold_req !== 1'b1) break;
      hold_n++;
    end
    checkOutput("s2_hold_len_from_ack", hold_n, 2 + SETTLE);
    step(1);
    waitIdle(10);
    checkOutput("s2_cfg_pulses", cfg_pulses - cfg0, 1);

    // Consecutive scale edits while waiting for a boundary coalesce.
    cfg0 = cfg_pulses;
    applyStimulus(16'd16000, 3'd1, 2'd0, 1'b0);
    step(1);
    applyStimulus(16'd16000, 3'd2, 2'd0, 1'b0);
    step(1);
    applyStimulus(16'd16000, 3'd3, 2'd0, 1'b0);
    step(1);
    frame_done = 1'b1;
    step(1);
    frame_done = 1'b0;
    waitHold(10);
    hold_ack = 1'b1;
    step(1);
    hold_ack = 1'b0;
    waitIdle(100);
    checkOutput("s3_cfg_pulses", cfg_pulses - cfg0, 1);
    checkOutput("s3_scale", 32'(active_scale_factor), 32'd3);

    // Mode edit reverted before any boundary.
    cfg0 = cfg_pulses;
    hold0 = hold_cycles;
    applyStimulus(16'd16000, 3'd3, 2'd2, 1'b0);
    step(3);
    checkOutput("s4_busy_waiting", 32'(busy), 32'd1);
    applyStimulus(16'd16000, 3'd3, 2'd0, 1'b0);
    step(10);
    checkOutput("s4_busy_after_revert", 32'(busy), 32'd0);
    checkOutput("s4_cfg_pulses", cfg_pulses - cfg0, 0);
    checkOutput("s4_hold_cycles", hold_cycles - hold0, 0);

    // Live enable with no ack: commit after the full timeout.
    hold0 = hold_cycles;
    applyStimulus(16'd16000, 3'd3, 2'd0, 1'b1);
    dp_idle = 1'b1;
    waitHold(10);
    dp_idle = 1'b0;
    waitIdle(TIMEOUT + 100);
    checkOutput("s5_hold_cycles", hold_cycles - hold0, TIMEOUT + 1 + SETTLE);
    checkOutput("s5_live", 32'(active_live), 32'd1);
    checkOutput("s5_err_set", 32'(timeout_err), 32'd1);
    step(20);
    checkOutput("s5_err_sticky", 32'(timeout_err), 32'd1);
    clear_err = 1'b1;
    step(1);
    clear_err = 1'b0;
    checkOutput("s5_err_cleared", 32'(timeout_err), 32'd0);

    // Rate edit during SETTLE starts a second transaction.
    cfg0 = cfg_pulses;
    applyStimulus(16'd16000, 3'd5, 2'd0, 1'b1);
    dp_idle = 1'b1;
    waitHold(10);
    dp_idle = 1'b0;
    hold_ack = 1'b1;
    step(1);
    hold_ack = 1'b0;
    step(4);
    checkOutput("s6_in_settle", 32'(hold_req), 32'd1);
    applyStimulus(16'd44100, 3'd5, 2'd0, 1'b1);
    step(2);
    checkOutput("s6_first_rate", 32'(active_sampling_rate), 32'd16000);
    checkOutput("s6_first_scale", 32'(active_scale_factor), 32'd5);
    dp_idle = 1'b1;
    hold_ack = 1'b1;
    step(60);
    dp_idle = 1'b0;
    hold_ack = 1'b0;
    checkOutput("s6_idle", 32'(busy), 32'd0);
    checkOutput("s6_cfg_pulses", cfg_pulses - cfg0, 2);
    checkOutput("s6_final_rate", 32'(active_sampling_rate), 32'd44100);

    // Randomized edits and handshakes against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       sampling_rate = rate_tab[$urandom_range(0, 3)];
          1:       scale_factor = 3'($urandom_range(0, 7));
          2:       mode = 2'($urandom_range(0, 3));
          default: live = ~live;
        endcase
      end
      frame_done = ($urandom_range(0, 5) == 0);
      dp_idle    = ($urandom_range(0, 9) == 0);
      hold_ack   = ($urandom_range(0, 3) == 0);
      clear_err  = ($urandom_range(0, 49) == 0);
      step(1);
    end
    frame_done = 1'b0;
    clear_err  = 1'b0;
    dp_idle    = 1'b1;
    hold_ack   = 1'b1;
    waitIdle(TIMEOUT + 100);
    dp_idle  = 1'b0;
    hold_ack = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/param_apply_ctrl.md
Name: param_apply_ctrl

Overview:
- Sits between param_selector and the autotune audio datapath (sampler, FFT/pitch-shift pipeline).
- Watches the user-selected parameters, which can change at any time from button presses.
- Commits a change to the datapath only at a frame boundary, while the pipeline is held.
- Coalesces rapid successive edits into one update, and reports a sticky error if the datapath never acknowledges the hold.

Parameters:
- DEF_RATE, 16'd8000, reset value of active_sampling_rate
- DEF_SCALE, 3'd0, reset value of active_scale_factor
- DEF_MODE, 2'd0, reset value of active_mode
- DEF_LIVE, 1'b0, reset value of active_live
- SETTLE_CYCLES, 16, cycles hold_req stays high after commit (min 1)
- TIMEOUT_CYCLES, 4096, max cycles to wait for hold_ack in STALL (min 1)

Ports:
- clk_65mhz  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sampling_rate  in  16  requested rate from param_selector
- scale_factor  in  3  requested musical scale factor
- mode  in  2  requested display/processing mode
- live  in  1  requested live-input enable
- frame_done  in  1  one-cycle pulse at datapath frame boundary
- dp_idle  in  1  datapath idle (no frame in flight)
- hold_ack  in  1  datapath has stalled in response to hold_req
- clear_err  in  1  clears timeout_err
- hold_req  out  1  request datapath stall
- active_sampling_rate  out  16  committed rate
- active_scale_factor  out  3  committed scale
- active_mode  out  2  committed mode
- active_live  out  1  committed live
- cfg_update  out  1  one-cycle pulse when active_* change
- busy  out  1  high in any state except IDLE
- timeout_err  out  1  sticky, set on hold_ack timeout

Behaviour:
- Reset (rst_n low, any time, including mid-transaction):
  - state IDLE, counters 0.
  - active_* = DEF_* values.
  - hold_req, cfg_update, busy, timeout_err all 0.
- Change detection: diff = {sampling_rate, scale_factor, mode, live} != {active_*}, compared every cycle.
- All outputs are registered. hold_req and busy are Moore decodes of the state register. hold_req = 1 in STALL, APPLY and SETTLE.
- State machine:
  - IDLE: diff seen at cycle N -> WAIT_FRAME at N+1.
  - WAIT_FRAME: frame_done=1 or dp_idle=1 at cycle M -> STALL at M+1.
    - If diff drops to 0 while waiting (user reverted), return to IDLE with no update.
  - STALL: hold_ack=1 -> APPLY next cycle, timeout counter cleared.
    - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 -> APPLY next cycle and timeout_err <= 1.
  - APPLY (exactly 1 cycle):
    - active_* <= current inputs (latest values, so edits made during WAIT_FRAME/STALL coalesce).
    - cfg_update = 1 during the cycle after APPLY.
    - Next state SETTLE with settle counter = 0.
  - SETTLE: stay SETTLE_CYCLES cycles, then IDLE; hold_req falls on entering IDLE.
    - Input changes during SETTLE are not applied. They appear as diff in IDLE and start a new transaction.
- Latency: hold_ack at cycle K -> active_* and cfg_update visible at K+2 -> hold_req low at K+2+SETTLE_CYCLES.
- frame_done and dp_idle are ignored outside WAIT_FRAME. hold_ack is ignored outside STALL.
- timeout_err:
  - Set only by a timeout.
  - Cleared by clear_err=1 when no timeout occurs that same cycle; simultaneous set wins.
- Widths match param_selector outputs exactly; no arithmetic on parameter values.

Test Plan:
1. rst_n low mid-SETTLE -> immediately active_sampling_rate=8000, hold_req=0, busy=0, cfg_update=0; after release stays IDLE with inputs equal to DEFs.
2. sampling_rate 8000->16000, frame_done pulse 5 cycles later, hold_ack 3 cycles after hold_req -> active_sampling_rate=16000 two cycles after ack, single cfg_update pulse, hold_req high for exactly 2+16 cycles from the ack cycle.
3. scale_factor 0->1->2->3 in consecutive cycles while in WAIT_FRAME, then frame_done and hold_ack -> one cfg_update, active_scale_factor=3.
4. mode 0->2 then back to 0 before frame_done -> returns to IDLE, no hold_req, no cfg_update.
5. live 0->1, dp_idle=1, hold_ack never asserted -> APPLY after 4096 STALL cycles, active_live=1, timeout_err=1 and stays 1; clear_err pulse -> timeout_err=0.
6. Input change during SETTLE (rate 16000->44100) -> first commit unaffected, a second full transaction follows, ending with active_sampling_rate=44100 and two cfg_update pulses total.
